fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the combinational instruction ROM. Owns the PC, drives the ROM address
//  and captures each returned word into a small queue. The queue feeds decode over a valid/ready handshake.
//  Branch/jump redirects from execute flush the queue. Sits between the ROM and the decode stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word-aligned
//  QDEPTH     2              fetch queue entries; power of two, >=2
//  ROM_WORDS  32             number of valid ROM words; word index >= ROM_WORDS is out of range
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   reset, synchronous, active-low
//  rom_addr        out  32  byte address to ROM; ROM indexes with rom_addr[31:2]
//  rom_instr       in   32  ROM read data, combinational from rom_addr
//  redirect_valid  in   1   execute requests PC change this cycle
//  redirect_pc     in   32  new fetch PC
//  dec_valid       out  1   queue head valid
//  dec_ready       in   1   decode accepts head
//  dec_instr       out  32  head instruction
//  dec_pc          out  32  head PC
//  dec_fault       out  1   head is a fetch fault: misaligned or out-of-range PC
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, queue count=0, all entry storage=0, state=FETCH.
//    Result: dec_valid=0, dec_instr=0, dec_pc=0, dec_fault=0, rom_addr=RESET_PC. Reset overrides all other inputs.
//  - rom_addr = pc register; no combinational path from inputs to rom_addr.
//  - FSM states FETCH, FAULT.
//    FETCH: push when !full && !redirect_valid.
//      fault = (pc[1:0]!=0) || (pc[31:2] >= ROM_WORDS).
//      Push entry {pc, fault ? NOP_INSTR : rom_instr, fault}. Then pc <= pc+4, mod 2^32.
//      A faulting push moves state to FAULT.
//    FAULT: no pushes; pc holds. Only a redirect leaves this state.
//  - Redirect (redirect_valid=1) has priority over push, in either state:
//    queue count <= 0, pc <= redirect_pc, state <= FETCH. No push that cycle.
//    A misaligned redirect_pc is not rejected; it becomes a fault entry on the next fetch.
//  - Dequeue: dec_valid = (count!=0). dec_* show the head entry. Pop on dec_valid && dec_ready.
//    A handshake in a redirect cycle counts as completed for decode; the flush still clears the queue.
//  - Full uses the registered count: no push when count==QDEPTH, even if a pop happens that cycle.
//    Push and pop in the same cycle leave count unchanged.
//  - Latency: word at pc is pushed at the edge ending the cycle in which rom_addr=pc.
//    It is visible on dec_* the next cycle.
//    After reset release: dec_valid=1 with dec_pc=RESET_PC one cycle later.
//  - Throughput: 1 instr/cycle while dec_ready=1.
//    dec_ready=0 fills the queue in QDEPTH cycles, then fetch stalls with pc held.
//  - Queue pointers wrap mod QDEPTH; count is $clog2(QDEPTH)+1 bits. Order is strictly FIFO.
//  - dec_* hold stable while dec_valid && !dec_ready, except on a redirect flush.
// STRUCTURE
//  - Shared package crane_pkg holds:
//    NOP_INSTR = 32'h0000_0013 (addi x0,x0,0)
//    default RESET_PC
//    fetch_state_t enum {FETCH, FAULT}
//  - One sub-module, fetch_queue: synchronous FIFO, width 65 = {fault, pc, instr}, depth QDEPTH.
//    Ports: push, pop, flush, full, empty, head.
//  - Top level: pc register, FSM, fault detect, push/redirect priority.
// TESTING
//  1. Reset, dec_ready=1 constant, ROM word i = 32'h1000_0000+i
//     -> dec_pc 0,4,8,.. one per cycle; dec_instr matches; first dec_valid 1 cycle after rst_n rises.
//  2. dec_ready=0 for 5 cycles from reset
//     -> queue holds pc 0,4; rom_addr stalls at 8; dec_pc=0 stable.
//     Raise dec_ready -> 0,4,8,12 in order with no gaps or duplicates.
//  3. redirect_valid=1, redirect_pc=0x10 while 2 entries queued
//     -> next cycle dec_valid=0, rom_addr=0x10; following cycle dec_pc=0x10.
//  4. Run up to pc=0x7C (ROM_WORDS=32)
//     -> entry pc 0x80 has dec_fault=1, dec_instr=32'h0000_0013.
//     State FAULT, rom_addr held at 0x84, no further pushes until a redirect to 0x0 resumes fetch.
//  5. redirect_pc=0x6 -> single entry pc 0x6 with dec_fault=1; fetch stops.
//  6. rst_n=0 for one cycle mid-stream while full and redirect_valid=1
//     -> all outputs zero, rom_addr=RESET_PC; redirect ignored.

Source files
------------

// File: rtl/crane_pkg.sv
// Shared definitions for the fetch front end: constants, FSM state type,
// fetch-queue entry layout and the fetch-fault predicate.
package crane_pkg;

  // Canonical RISC-V NOP (addi x0,x0,0), substituted for faulting fetches.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  // Default fetch PC after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // Width of one queue entry: {fault, pc, instr}.
  localparam int          ENTRY_W          = 65;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A fetch faults when the PC is not word-aligned or its word index lies
  // beyond the populated part of the ROM.
  function automatic logic is_fetch_fault(input logic [31:0] pc,
                                          input logic [31:0] rom_words);
    logic [31:0] word_idx;
    word_idx = {2'b00, pc[31:2]};
    return (pc[1:0] != 2'b00) || (word_idx >= rom_words);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched entries between the ROM and decode.
// A flush empties it in one cycle and takes priority over push and pop.
module fetch_queue
  import crane_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  fetch_entry_t  mem_q [QDEPTH];

  logic do_push_s;
  logic do_pop_s;

  assign full  = (count_q == CW'(QDEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign head  = mem_q[rd_ptr_q];

  // Qualify requests: never write when full, never read when empty, and
  // let a flush suppress both.
  always_comb begin
    do_push_s = push && !full && !flush;
    do_pop_s  = pop && !empty && !flush;
  end

  // Next-state for pointers and occupancy; pointers wrap naturally since
  // the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers; reset also clears every entry so the head
  // reads as all-zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM,
// tags faulting fetches and feeds decode through a small FIFO. A redirect
// from execute flushes the FIFO and restarts fetch at the new PC.
module fetch_ctrl
  import crane_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          QDEPTH    = 2,
  parameter int          ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_fault
);

  logic [31:0]  pc_q, pc_d;
  fetch_state_t state_q, state_d;

  logic         q_full_s;
  logic         q_empty_s;
  logic         push_s;
  logic         pop_s;
  logic         fault_s;
  fetch_entry_t push_entry_s;
  fetch_entry_t head_s;

  // The ROM is always addressed straight from the PC register.
  assign rom_addr = pc_q;

  assign dec_valid = !q_empty_s;
  assign dec_instr = head_s.instr;
  assign dec_pc    = head_s.pc;
  assign dec_fault = head_s.fault;
  assign pop_s     = dec_valid && dec_ready;

  // Fault detection and the entry that would be captured this cycle.
  always_comb begin
    fault_s            = is_fetch_fault(pc_q, 32'(ROM_WORDS));
    push_entry_s.fault = fault_s;
    push_entry_s.pc    = pc_q;
    if (fault_s) begin
      push_entry_s.instr = NOP_INSTR;
    end else begin
      push_entry_s.instr = rom_instr;
    end
  end

  // Redirect beats push; in FETCH a push happens whenever the registered
  // occupancy leaves room, and a faulting push parks the FSM in FAULT.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push_s  = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = FETCH;
      push_s  = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!q_full_s) begin
            push_s  = 1'b1;
            pc_d    = pc_q + 32'd4;
            if (fault_s) begin
              state_d = FAULT;
            end else begin
              state_d = FETCH;
            end
          end else begin
            push_s  = 1'b0;
            pc_d    = pc_q;
            state_d = FETCH;
          end
        end
        FAULT: begin
          push_s  = 1'b0;
          pc_d    = pc_q;
          state_d = FAULT;
        end
        default: begin
          push_s  = 1'b0;
          pc_d    = pc_q;
          state_d = FETCH;
        end
      endcase
    end
  end

  // PC and fetch FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .head      (head_s)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues the entries decode should
// accept; a negedge monitor compares every handshake against that queue.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_fault      (dec_fault)
  );

  // ROM model: word i holds 0x1000_0000 + i for the 32 populated words.
  assign rom_instr = (rom_addr[31:2] < 30'd32) ? (32'h1000_0000 + {2'b00, rom_addr[31:2]})
                                                : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every completed handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && dec_valid && dec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_handshake got pc=%h instr=%h fault=%b", dec_pc, dec_instr, dec_fault);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dec_pc !== e.pc || dec_instr !== e.instr || dec_fault !== e.fault) begin
          errors++;
          $display("FAIL handshake got pc=%h instr=%h fault=%b expected pc=%h instr=%h fault=%b",
                   dec_pc, dec_instr, dec_fault, e.pc, e.instr, e.fault);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exp_q.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Test 1: reset values, then one instruction per cycle.
    tick();
    tick();
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_fault", {31'd0, dec_fault}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    for (int i = 0; i < 6; i++) exp_push(32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0);
    rst_n = 1'b1;
    chk("t1_valid_first_cycle", {31'd0, dec_valid}, 32'd0);
    tick();
    chk("t1_valid_after_1", {31'd0, dec_valid}, 32'd1);
    chk("t1_pc_after_1", dec_pc, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    dec_ready = 1'b0;
    chk("t1_all_accepted", 32'(exp_q.size()), 32'd0);

    // Test 2: back-pressure from reset fills the queue and stalls fetch.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t2_pc_stable_mid", dec_pc, 32'h0);
    tick();
    tick();
    chk("t2_rom_addr_stall", rom_addr, 32'h8);
    chk("t2_valid", {31'd0, dec_valid}, 32'd1);
    chk("t2_pc_stable", dec_pc, 32'h0);
    chk("t2_instr_stable", dec_instr, 32'h1000_0000);
    for (int i = 0; i < 4; i++) exp_push(32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dec_ready = 1'b0;
    chk("t2_all_accepted", 32'(exp_q.size()), 32'd0);

    // Test 3: redirect with two entries queued flushes them.
    tick();
    chk("t3_pre_valid", {31'd0, dec_valid}, 32'd1);
    chk("t3_pre_pc", dec_pc, 32'h10);
    chk("t3_pre_rom_addr", rom_addr, 32'h18);
    do_redirect(32'h10);
    chk("t3_flush_valid", {31'd0, dec_valid}, 32'd0);
    chk("t3_rom_addr", rom_addr, 32'h10);
    exp_push(32'h10, 32'h1000_0004, 1'b0);
    exp_push(32'h14, 32'h1000_0005, 1'b0);
    dec_ready = 1'b1;
    tick();
    chk("t3_valid_after", {31'd0, dec_valid}, 32'd1);
    chk("t3_pc_after", dec_pc, 32'h10);
    tick();
    tick();
    dec_ready = 1'b0;
    chk("t3_all_accepted", 32'(exp_q.size()), 32'd0);

    // Test 4: run past the last ROM word into an out-of-range fault.
    do_redirect(32'h70);
    dec_ready = 1'b1;
    exp_push(32'h70, 32'h1000_001C, 1'b0);
    exp_push(32'h74, 32'h1000_001D, 1'b0);
    exp_push(32'h78, 32'h1000_001E, 1'b0);
    exp_push(32'h7C, 32'h1000_001F, 1'b0);
    exp_push(32'h80, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("t4_all_accepted", 32'(exp_q.size()), 32'd0);
    chk("t4_rom_addr_held", rom_addr, 32'h84);
    tick();
    tick();
    tick();
    chk("t4_no_push_valid", {31'd0, dec_valid}, 32'd0);
    chk("t4_rom_addr_still", rom_addr, 32'h84);
    do_redirect(32'h0);
    exp_push(32'h0, 32'h1000_0000, 1'b0);
    exp_push(32'h4, 32'h1000_0001, 1'b0);
    tick();
    tick();
    tick();
    dec_ready = 1'b0;
    chk("t4_resume_accepted", 32'(exp_q.size()), 32'd0);

    // Test 5: misaligned redirect yields one fault entry and fetch stops.
    tick();
    do_redirect(32'h6);
    dec_ready = 1'b1;
    exp_push(32'h6, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_all_accepted", 32'(exp_q.size()), 32'd0);
    chk("t5_valid", {31'd0, dec_valid}, 32'd0);
    chk("t5_rom_addr", rom_addr, 32'hA);

    // Test 6: reset while full with a simultaneous redirect.
    dec_ready = 1'b0;
    do_redirect(32'h0);
    tick();
    tick();
    tick();
    chk("t6_full_valid", {31'd0, dec_valid}, 32'd1);
    chk("t6_full_rom_addr", rom_addr, 32'h8);
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exp_q.delete();
    chk("t6_valid", {31'd0, dec_valid}, 32'd0);
    chk("t6_pc", dec_pc, 32'h0);
    chk("t6_instr", dec_instr, 32'h0);
    chk("t6_fault", {31'd0, dec_fault}, 32'd0);
    chk("t6_rom_addr", rom_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t6_restart_valid", {31'd0, dec_valid}, 32'd1);
    chk("t6_restart_pc", dec_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
